// File: rtl/risc15_mem_responder.sv
// RISC15 load/store memory responder: one request at a time, programmable
// wait states, internal word RAM, registered ready/err completion pulse.
module risc15_mem_responder #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic req;
  logic go_done;
  logic addr_ok;
  logic op_err;
  logic do_wr;
  logic do_rd;
  logic ready_d;
  logic err_d;
  logic [AW-1:0] idx;

  logic [DATA_W-1:0] ram [DEPTH];

  always_comb begin
    req     = mem_read | mem_write;
    go_done = (state_q == S_WAIT) && (cnt_q == 4'd0);
    addr_ok = {1'b0, addr_q} < DEPTH_V;
    op_err  = (rd_q & wr_q) | ~addr_ok;
    do_wr   = go_done & wr_q & ~op_err;
    do_rd   = go_done & rd_q & ~wr_q;
    idx     = addr_q[AW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_d = go_done;
    err_d   = go_done & op_err;
    busy    = (state_q != S_IDLE);
  end

  // Request is captured once; inputs are don't-care until back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state_q == S_IDLE) && req) begin
      rd_q    <= mem_read;
      wr_q    <= mem_write;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= ready_d;
      mem_err   <= err_d;
      if (do_rd) begin
        mem_rdata <= addr_ok ? ram[idx] : '0;
      end
    end
  end

  // RAM contents survive reset; a reset in WAIT parks the FSM so no write.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      ram[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_risc15_mem_responder.sv
// Scoreboard bench for risc15_mem_responder: three instances with
// WAIT_CYC of 2, 0 and 1 share clock and reset.
module tb_risc15_mem_responder;

  typedef struct {
    int          inst;
    int          cyc;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        rd    [3];
  logic        wr    [3];
  logic [15:0] addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic        ready [3];
  logic        err   [3];
  logic        busy  [3];

  int   cyc;
  int   total;
  int   bad;
  exp_t sbq [$];
  exp_t mon_e;

  risc15_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(2)
  ) u_w2 (
    .clk(clk), .reset(reset),
    .mem_read(rd[0]), .mem_write(wr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_rdata(rdata[0]), .mem_ready(ready[0]),
    .mem_err(err[0]), .busy(busy[0])
  );

  risc15_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(0)
  ) u_w0 (
    .clk(clk), .reset(reset),
    .mem_read(rd[1]), .mem_write(wr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_rdata(rdata[1]), .mem_ready(ready[1]),
    .mem_err(err[1]), .busy(busy[1])
  );

  risc15_mem_responder #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(1)
  ) u_w1 (
    .clk(clk), .reset(reset),
    .mem_read(rd[2]), .mem_write(wr[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]),
    .mem_rdata(rdata[2]), .mem_ready(ready[2]),
    .mem_err(err[2]), .busy(busy[2])
  );

  localparam int WC [3] = '{2, 0, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ready[i]) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready inst=%0d cyc=%0d", i, cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.inst != i || mon_e.cyc != cyc ||
              rdata[i] !== mon_e.rdata || err[i] !== mon_e.err) begin
            bad++;
            $display("FAIL resp inst=%0d cyc=%0d got rdata=%h err=%b want inst=%0d cyc=%0d rdata=%h err=%b",
                     i, cyc, rdata[i], err[i], mon_e.inst,
                     mon_e.cyc, mon_e.rdata, mon_e.err);
          end
        end
      end else if (err[i]) begin
        total++;
        bad++;
        $display("FAIL err_without_ready inst=%0d cyc=%0d got=1 want=0",
                 i, cyc);
      end
    end
  end

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL idle_timeout inst=%0d got busy=1 want 0", i);
    end
  endtask

  // Called just after a negedge with instance i idle.
  task automatic issue(input int i, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_rd, input logic exp_err);
    exp_t e;
    rd[i]    = r;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    e.inst  = i;
    e.cyc   = cyc + WC[i] + 2;
    e.rdata = exp_rd;
    e.err   = exp_err;
    sbq.push_back(e);
    @(negedge clk);
    rd[i]    = 1'b0;
    wr[i]    = 1'b0;
    addr[i]  = 16'hFFFF;
    wdata[i] = 16'h0;
    total++;
    if (busy[i] !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_sample inst=%0d got=%b want=1",
               i, busy[i]);
    end
    wait_idle(i);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rdata[i] !== 16'h0 || ready[i] !== 1'b0 ||
          err[i] !== 1'b0 || busy[i] !== 1'b0) begin
        bad++;
        $display("FAIL %s inst=%0d got rdata=%h rdy=%b err=%b busy=%b want all 0",
                 tag, i, rdata[i], ready[i], err[i], busy[i]);
      end
    end
  endtask

  initial begin
    int c0;
    cyc   = 0;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd[i]    = 1'b0;
      wr[i]    = 1'b0;
      addr[i]  = 16'h0;
      wdata[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // WAIT_CYC=2: basic write/read, range errors, aliasing, rd+wr conflict
    issue(0, 0, 1, 16'd5,   16'hBEEF, 16'h0000, 0);
    issue(0, 1, 0, 16'd5,   16'h0000, 16'hBEEF, 0);
    issue(0, 1, 0, 16'd300, 16'h0000, 16'h0000, 1);
    issue(0, 0, 1, 16'd44,  16'h4444, 16'h0000, 0);
    issue(0, 0, 1, 16'd300, 16'hDEAD, 16'h0000, 1);
    issue(0, 1, 0, 16'd44,  16'h0000, 16'h4444, 0);
    issue(0, 0, 1, 16'd7,   16'h0777, 16'h4444, 0);
    issue(0, 1, 1, 16'd7,   16'h1234, 16'h4444, 1);
    issue(0, 1, 0, 16'd7,   16'h0000, 16'h0777, 0);
    issue(0, 0, 1, 16'd9,   16'h0909, 16'h0777, 0);

    // Reset while a write of 0x5555 to addr 9 sits in WAIT
    rd[0]    = 1'b0;
    wr[0]    = 1'b1;
    addr[0]  = 16'd9;
    wdata[0] = 16'h5555;
    @(negedge clk);
    wr[0]   = 1'b0;
    addr[0] = 16'h0;
    reset   = 1'b1;
    #2;
    check_reset_outputs("reset_mid_wait");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("after_reset_quiet");

    issue(0, 1, 0, 16'd9,   16'h0000, 16'h0909, 0);
    issue(0, 0, 1, 16'd255, 16'h00FF, 16'h0909, 0);
    issue(0, 1, 0, 16'd255, 16'h0000, 16'h00FF, 0);
    issue(0, 1, 0, 16'd256, 16'h0000, 16'h0000, 1);

    // WAIT_CYC=0: read in the first idle cycle after a write
    issue(1, 0, 1, 16'd3, 16'hA5A5, 16'h0000, 0);
    issue(1, 1, 0, 16'd3, 16'h0000, 16'hA5A5, 0);

    // WAIT_CYC=1: back-to-back reads from a held request
    issue(2, 0, 1, 16'd10, 16'h1010, 16'h0000, 0);
    c0 = cyc;
    rd[2]   = 1'b1;
    addr[2] = 16'd10;
    for (int j = 0; j < 3; j++) begin
      mon_e.inst  = 2;
      mon_e.cyc   = c0 + 3 + 4 * j;
      mon_e.rdata = 16'h1010;
      mon_e.err   = 1'b0;
      sbq.push_back(mon_e);
    end
    repeat (10) @(negedge clk);
    rd[2] = 1'b0;
    wait_idle(2);

    repeat (5) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL missing_ready got pending=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
